lc3_execute: RTL and testbench
==============================

// Module: lc3_execute
// PURPOSE
//  LC3 Execute stage, directly downstream of Decode. Consumes the decode_out bundle
//  (IR, npc_out, E_Control, W_Control, Mem_Control) plus register-file operands.
//  Computes the ALU result, the effective address / branch target and the store data.
//  Registers its results toward MemAccess/Writeback and the Controller.
// PARAMETERS
//  (none) - word width is fixed at 16 bits (LC3 ISA).
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   synchronous, active-high
//  enable_execute   in   1   1 = capture this cycle's results; 0 = hold all registered outputs
//  IR               in   16  instruction from Decode
//  npc              in   16  PC+1 from Decode (npc_out)
//  E_Control        in   6   {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}
//  W_Control_in     in   2   writeback select; passed through
//  Mem_Control_in   in   1   memory-access control; passed through
//  VSR1             in   16  register-file value of sr1
//  VSR2             in   16  register-file value of sr2
//  bypass_alu_1     in   1   operand1 takes the registered aluout
//  bypass_alu_2     in   1   operand2 / store data takes the registered aluout
//  bypass_mem_1     in   1   operand1 takes Mem_Bypass_Val
//  bypass_mem_2     in   1   operand2 / store data takes Mem_Bypass_Val
//  Mem_Bypass_Val   in   16  forwarded memory read data
//  sr1              out  3   combinational: IR[8:6]
//  sr2              out  3   combinational: IR[11:9] for ST/STR/STI (opc 0011/0111/1011), else IR[2:0]
//  aluout           out  16  registered ALU result, or address for LEA
//  pcout            out  16  registered address-adder sum
//  M_Data           out  16  registered store data (bypassed operand2 register value)
//  dr               out  3   registered destination register
//  NZP              out  3   registered branch condition mask
//  IR_Exec          out  16  registered copy of IR
//  W_Control_out    out  2   registered W_Control_in
//  Mem_Control_out  out  1   registered Mem_Control_in
// BEHAVIOUR
//  - Reset: on a rising clock with reset=1, all registered outputs go to 0. Reset beats
//    enable_execute. An instruction in flight is discarded; no partial update survives.
//  - Latency: 1 cycle. Inputs sampled on edge N with enable_execute=1 appear after edge N.
//    enable_execute=0 holds every registered output, including IR_Exec and the pass-throughs.
//  - Operand select, with priority alu > mem > register file:
//    - opA = bypass_alu_1 ? aluout : bypass_mem_1 ? Mem_Bypass_Val : VSR1.
//    - regB = bypass_alu_2 ? aluout : bypass_mem_2 ? Mem_Bypass_Val : VSR2.
//    - opB = op2select ? regB : sext(IR[4:0]).
//  - ALU on alu_control: 00 ADD opA+opB (mod 2^16, carry dropped); 01 AND opA&opB;
//    10 NOT ~opA; 11 result 0.
//  - Address adder, pcout = base + offset (mod 2^16):
//    - base: pcselect2=1 gives npc, 0 gives opA.
//    - offset from pcselect1: 00 sext(IR[10:0]); 01 sext(IR[8:0]); 10 sext(IR[5:0]); 11 zero.
//  - aluout: ALU result for ADD/AND/NOT (opc 0001/0101/1001); adder sum for LEA (1110);
//    otherwise the ALU result.
//  - dr = IR[11:9] for ADD/AND/NOT/LD/LDR/LDI/LEA, else 0.
//  - NZP = IR[11:9] for BR (0000); 3'b111 for JMP (1100); else 0.
//  - M_Data = regB, always captured; meaningful only for stores.
//  - Bypass operands use the current registered aluout, i.e. the previous instruction's result.
//  - Simultaneous bypass_alu_x and bypass_mem_x: alu wins.
//  - No X propagation: alu_control=11 and unused fields still produce defined values.
// TESTING
//  1. Reset: reset=1 for 2 clocks with enable_execute=1 and nonzero inputs
//     -> all registered outputs 0 after each edge.
//  2. ADD register: IR=16'h1042 (ADD R0,R1,R2), E_Control=6'b000001, VSR1=16'h7FFF, VSR2=16'h0001
//     -> aluout=16'h8000, dr=0, sr1=1, sr2=2.
//     Then VSR2=16'h8001 -> aluout=16'h0000 (wrap).
//  3. AND immediate: IR=16'h5261 (AND R1,R1,#1), E_Control=6'b010000, VSR1=16'h00F3
//     -> aluout=16'h0001, dr=1.
//  4. BR target: IR=16'h0BFE (BRnp #-2), E_Control=6'b000110, npc=16'h3005
//     -> pcout=16'h3003, NZP=3'b101.
//  5. Bypass priority: ADD with bypass_alu_1=bypass_mem_1=1, prior aluout=16'h0010,
//     Mem_Bypass_Val=16'h0100, opB=16'h0001 -> aluout=16'h0011.
//     STR with bypass_mem_2=1 -> M_Data=Mem_Bypass_Val.
//  6. Stall: after a valid capture, drop enable_execute for 3 cycles while changing IR/VSR
//     -> outputs unchanged. Assert reset during the stall -> outputs 0 on that edge.

Source files
------------

// File: rtl/lc3_execute.sv
// LC3 execute stage: operand forwarding, ALU, address adder and the registered
// results handed on to MemAccess, Writeback and the Controller.
module lc3_execute (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_execute,
    input  logic [15:0] IR,
    input  logic [15:0] npc,
    input  logic [5:0]  E_Control,
    input  logic [1:0]  W_Control_in,
    input  logic        Mem_Control_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    input  logic        bypass_alu_1,
    input  logic        bypass_alu_2,
    input  logic        bypass_mem_1,
    input  logic        bypass_mem_2,
    input  logic [15:0] Mem_Bypass_Val,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [15:0] M_Data,
    output logic [2:0]  dr,
    output logic [2:0]  NZP,
    output logic [15:0] IR_Exec,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out
);

    localparam logic [3:0] OPC_BR  = 4'b0000;
    localparam logic [3:0] OPC_ADD = 4'b0001;
    localparam logic [3:0] OPC_LD  = 4'b0010;
    localparam logic [3:0] OPC_ST  = 4'b0011;
    localparam logic [3:0] OPC_AND = 4'b0101;
    localparam logic [3:0] OPC_LDR = 4'b0110;
    localparam logic [3:0] OPC_STR = 4'b0111;
    localparam logic [3:0] OPC_NOT = 4'b1001;
    localparam logic [3:0] OPC_LDI = 4'b1010;
    localparam logic [3:0] OPC_STI = 4'b1011;
    localparam logic [3:0] OPC_JMP = 4'b1100;
    localparam logic [3:0] OPC_LEA = 4'b1110;

    logic [15:0] aluout_q, aluout_d;
    logic [15:0] pcout_q, pcout_d;
    logic [15:0] mdata_q, mdata_d;
    logic [2:0]  dr_q, dr_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [15:0] ir_q;
    logic [1:0]  wctl_q;
    logic        memctl_q;

    logic [3:0]  opcode;
    logic [1:0]  alu_control;
    logic [1:0]  pcselect1;
    logic        pcselect2;
    logic        op2select;
    logic [15:0] op_a, reg_b, op_b, alu_res, base, offset;

    assign opcode      = IR[15:12];
    assign alu_control = E_Control[5:4];
    assign pcselect1   = E_Control[3:2];
    assign pcselect2   = E_Control[1];
    assign op2select   = E_Control[0];

    // Stores read their data register from the DR field so it can be forwarded like sr2.
    assign sr1 = IR[8:6];
    assign sr2 = (opcode == OPC_ST || opcode == OPC_STR || opcode == OPC_STI) ? IR[11:9] : IR[2:0];

    always_comb begin
        op_a = VSR1;
        if (bypass_alu_1)      op_a = aluout_q;
        else if (bypass_mem_1) op_a = Mem_Bypass_Val;

        reg_b = VSR2;
        if (bypass_alu_2)      reg_b = aluout_q;
        else if (bypass_mem_2) reg_b = Mem_Bypass_Val;

        op_b = op2select ? reg_b : {{11{IR[4]}}, IR[4:0]};

        case (alu_control)
            2'b00:   alu_res = op_a + op_b;
            2'b01:   alu_res = op_a & op_b;
            2'b10:   alu_res = ~op_a;
            default: alu_res = 16'h0000;
        endcase

        base = pcselect2 ? npc : op_a;
        case (pcselect1)
            2'b00:   offset = {{5{IR[10]}}, IR[10:0]};
            2'b01:   offset = {{7{IR[8]}}, IR[8:0]};
            2'b10:   offset = {{10{IR[5]}}, IR[5:0]};
            default: offset = 16'h0000;
        endcase
        pcout_d = base + offset;

        aluout_d = (opcode == OPC_LEA) ? pcout_d : alu_res;
        mdata_d  = reg_b;

        case (opcode)
            OPC_ADD, OPC_AND, OPC_NOT, OPC_LD, OPC_LDR, OPC_LDI, OPC_LEA: dr_d = IR[11:9];
            default: dr_d = 3'b000;
        endcase

        case (opcode)
            OPC_BR:  nzp_d = IR[11:9];
            OPC_JMP: nzp_d = 3'b111;
            default: nzp_d = 3'b000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aluout_q <= 16'h0000;
            pcout_q  <= 16'h0000;
            mdata_q  <= 16'h0000;
            dr_q     <= 3'b000;
            nzp_q    <= 3'b000;
            ir_q     <= 16'h0000;
            wctl_q   <= 2'b00;
            memctl_q <= 1'b0;
        end else if (enable_execute) begin
            aluout_q <= aluout_d;
            pcout_q  <= pcout_d;
            mdata_q  <= mdata_d;
            dr_q     <= dr_d;
            nzp_q    <= nzp_d;
            ir_q     <= IR;
            wctl_q   <= W_Control_in;
            memctl_q <= Mem_Control_in;
        end
    end

    assign aluout          = aluout_q;
    assign pcout           = pcout_q;
    assign M_Data          = mdata_q;
    assign dr              = dr_q;
    assign NZP             = nzp_q;
    assign IR_Exec         = ir_q;
    assign W_Control_out   = wctl_q;
    assign Mem_Control_out = memctl_q;

endmodule

// File: tb/tb_lc3_execute.sv
// Directed bench for lc3_execute: a vector table of independent instructions plus
// hand-written sequences for reset, forwarding and stall behaviour.
module tb_lc3_execute;

    logic        clock = 1'b0;
    logic        reset, enable_execute;
    logic [15:0] IR, npc, VSR1, VSR2, Mem_Bypass_Val;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control_in;
    logic        Mem_Control_in;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [2:0]  sr1, sr2, dr, NZP;
    logic [15:0] aluout, pcout, M_Data, IR_Exec;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lc3_execute dut (
        .clock(clock), .reset(reset), .enable_execute(enable_execute),
        .IR(IR), .npc(npc), .E_Control(E_Control),
        .W_Control_in(W_Control_in), .Mem_Control_in(Mem_Control_in),
        .VSR1(VSR1), .VSR2(VSR2),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .Mem_Bypass_Val(Mem_Bypass_Val),
        .sr1(sr1), .sr2(sr2), .aluout(aluout), .pcout(pcout), .M_Data(M_Data),
        .dr(dr), .NZP(NZP), .IR_Exec(IR_Exec),
        .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out)
    );

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  ectl;
        logic [15:0] vsr1;
        logic [15:0] vsr2;
        logic [15:0] exp_alu;
        logic [15:0] exp_pc;
        logic [15:0] exp_md;
        logic [2:0]  exp_dr;
        logic [2:0]  exp_nzp;
        logic [2:0]  exp_sr1;
        logic [2:0]  exp_sr2;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " aluout"}, aluout, 16'h0000);
        chk({tag, " pcout"}, pcout, 16'h0000);
        chk({tag, " M_Data"}, M_Data, 16'h0000);
        chk({tag, " dr"}, {13'd0, dr}, 16'h0000);
        chk({tag, " NZP"}, {13'd0, NZP}, 16'h0000);
        chk({tag, " IR_Exec"}, IR_Exec, 16'h0000);
        chk({tag, " W_Control_out"}, {14'd0, W_Control_out}, 16'h0000);
        chk({tag, " Mem_Control_out"}, {15'd0, Mem_Control_out}, 16'h0000);
    endtask

    task automatic drive(input logic [15:0] ir_v, input logic [15:0] npc_v, input logic [5:0] e_v,
                         input logic [15:0] v1, input logic [15:0] v2);
        IR = ir_v; npc = npc_v; E_Control = e_v; VSR1 = v1; VSR2 = v2;
    endtask

    initial begin
        //            ir       npc      ectl       vsr1     vsr2     alu      pc       md       dr    nzp     sr1   sr2
        vecs[0] = '{16'h1042, 16'h3000, 6'b000001, 16'h7FFF, 16'h0001, 16'h8000, 16'h8041, 16'h0001, 3'd0, 3'b000, 3'd1, 3'd2};
        vecs[1] = '{16'h1042, 16'h3000, 6'b000001, 16'h7FFF, 16'h8001, 16'h0000, 16'h8041, 16'h8001, 3'd0, 3'b000, 3'd1, 3'd2};
        vecs[2] = '{16'h5261, 16'h3000, 6'b010000, 16'h00F3, 16'h1234, 16'h0001, 16'h0354, 16'h1234, 3'd1, 3'b000, 3'd1, 3'd1};
        vecs[3] = '{16'h0BFE, 16'h3005, 6'b000110, 16'h0000, 16'h0000, 16'hFFFE, 16'h3003, 16'h0000, 3'd0, 3'b101, 3'd7, 3'd6};
        vecs[4] = '{16'h94FF, 16'h3000, 6'b100000, 16'h00FF, 16'h0000, 16'hFF00, 16'hFDFE, 16'h0000, 3'd2, 3'b000, 3'd3, 3'd7};
        vecs[5] = '{16'hEA03, 16'h4000, 6'b000110, 16'h0000, 16'h5555, 16'h4003, 16'h4003, 16'h5555, 3'd5, 3'b000, 3'd0, 3'd3};
        vecs[6] = '{16'hC080, 16'h3000, 6'b111100, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 3'd0, 3'b111, 3'd2, 3'd0};
        vecs[7] = '{16'h39FF, 16'h3010, 6'b000110, 16'h0010, 16'hABCD, 16'h000F, 16'h300F, 16'hABCD, 3'd0, 3'b000, 3'd7, 3'd4};
        vecs[8] = '{16'h1042, 16'h3000, 6'b110001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0041, 16'hFFFF, 3'd0, 3'b000, 3'd1, 3'd2};
        vecs[9] = '{16'h6684, 16'h3000, 6'b001000, 16'h2000, 16'h0000, 16'h2004, 16'h2004, 16'h0000, 3'd3, 3'b000, 3'd2, 3'd4};

        reset = 1'b1; enable_execute = 1'b1;
        drive(16'h1042, 16'h3000, 6'b000001, 16'h1111, 16'h2222);
        W_Control_in = 2'b11; Mem_Control_in = 1'b1; Mem_Bypass_Val = 16'h4444;
        bypass_alu_1 = 1'b0; bypass_alu_2 = 1'b0; bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b0;

        // Reset held two edges with live, nonzero inputs and enable high.
        tick(); check_zero("reset edge1");
        tick(); check_zero("reset edge2");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ir, vecs[i].npc, vecs[i].ectl, vecs[i].vsr1, vecs[i].vsr2);
            W_Control_in = 2'(i); Mem_Control_in = i[0];
            #1;
            chk($sformatf("v%0d sr1", i), {13'd0, sr1}, {13'd0, vecs[i].exp_sr1});
            chk($sformatf("v%0d sr2", i), {13'd0, sr2}, {13'd0, vecs[i].exp_sr2});
            tick();
            chk($sformatf("v%0d aluout", i), aluout, vecs[i].exp_alu);
            chk($sformatf("v%0d pcout", i), pcout, vecs[i].exp_pc);
            chk($sformatf("v%0d M_Data", i), M_Data, vecs[i].exp_md);
            chk($sformatf("v%0d dr", i), {13'd0, dr}, {13'd0, vecs[i].exp_dr});
            chk($sformatf("v%0d NZP", i), {13'd0, NZP}, {13'd0, vecs[i].exp_nzp});
            chk($sformatf("v%0d IR_Exec", i), IR_Exec, vecs[i].ir);
            chk($sformatf("v%0d W_Control_out", i), {14'd0, W_Control_out}, {14'd0, 2'(i)});
            chk($sformatf("v%0d Mem_Control_out", i), {15'd0, Mem_Control_out}, {15'd0, i[0]});
        end

        // Forwarding: ADD R0,R1,#1 sets aluout to 0x0010 for the following instructions.
        drive(16'h1061, 16'h3000, 6'b000000, 16'h000F, 16'h0000);
        tick(); chk("byp seed aluout", aluout, 16'h0010);

        drive(16'h1061, 16'h3000, 6'b000000, 16'hDEAD, 16'h0000);
        Mem_Bypass_Val = 16'h0100; bypass_alu_1 = 1'b1; bypass_mem_1 = 1'b1;
        tick(); chk("byp alu over mem", aluout, 16'h0011);

        bypass_alu_1 = 1'b0;
        tick(); chk("byp mem only", aluout, 16'h0101);

        // STR R3,R1,#2 with store data from the memory bypass.
        drive(16'h7642, 16'h3000, 6'b001000, 16'h0100, 16'h1111);
        bypass_mem_1 = 1'b0; bypass_mem_2 = 1'b1; Mem_Bypass_Val = 16'hBEEF;
        #1; chk("str sr2", {13'd0, sr2}, 16'd3);
        tick();
        chk("str M_Data mem", M_Data, 16'hBEEF);
        chk("str pcout", pcout, 16'h0102);
        chk("str aluout", aluout, 16'h0102);
        bypass_alu_2 = 1'b1;
        tick(); chk("str M_Data alu over mem", M_Data, 16'h0102);
        bypass_alu_2 = 1'b0; bypass_mem_2 = 1'b0;

        // Stall: capture an ADD, then hold through three edges of changing inputs.
        drive(16'h1042, 16'h3000, 6'b000001, 16'h7FFF, 16'h0001);
        W_Control_in = 2'd2; Mem_Control_in = 1'b1;
        tick(); chk("stall capture aluout", aluout, 16'h8000);
        enable_execute = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(16'h5261 + 16'(k), 16'h1000, 6'b010000, 16'h00F3 + 16'(k), 16'h0F0F);
            W_Control_in = 2'd1; Mem_Control_in = 1'b0;
            tick();
            chk($sformatf("stall%0d aluout", k), aluout, 16'h8000);
            chk($sformatf("stall%0d pcout", k), pcout, 16'h8041);
            chk($sformatf("stall%0d M_Data", k), M_Data, 16'h0001);
            chk($sformatf("stall%0d IR_Exec", k), IR_Exec, 16'h1042);
            chk($sformatf("stall%0d W_Control_out", k), {14'd0, W_Control_out}, 16'd2);
            chk($sformatf("stall%0d Mem_Control_out", k), {15'd0, Mem_Control_out}, 16'd1);
        end
        reset = 1'b1;
        tick(); check_zero("reset in stall");
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
